// File: rtl/and_arb_pkg.sv
// Shared encodings for the and_share_arbiter slice: result-register state and
// the logic operation selector used when AND_ARB_LOGIC_OP_EN is defined.
package and_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

endpackage

// File: rtl/and_share_arbiter_rr_pick.sv
// Round-robin picker: rotates req by ptr and priority-scans from the pointer,
// returning a one-hot grant and the absolute index of the winner.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;

    // Shifting the doubled vector right by ptr gives req rotated so ptr sits at bit 0.
    assign rot = N_REQ'({req, req} >> ptr);

    always_comb begin
        any = 1'b0;
        off = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(N_REQ))
            sum = sum - (ID_W+1)'(N_REQ);
        idx = sum[ID_W-1:0];
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/and_share_arbiter.sv
// Shares one registered bitwise logic unit among N_REQ requesters, round-robin.
// Define AND_ARB_LOGIC_OP_EN to add per-requester op_in (AND/OR/XOR/NOR select).
module and_share_arbiter
    import and_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
`ifdef AND_ARB_LOGIC_OP_EN
    input  logic [N_REQ*2-1:0]     op_in,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready
);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_res;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // reset_n gates acc so gnt is forced low while reset is asserted.
    assign acc = reset_n && ((state == ST_EMPTY) || (out_valid && out_ready));
    assign gnt = acc ? pick_gnt : '0;

    always_comb begin
        opa = a_in[int'(pick_idx)*WIDTH +: WIDTH];
        opb = b_in[int'(pick_idx)*WIDTH +: WIDTH];
`ifdef AND_ARB_LOGIC_OP_EN
        case (op_t'(op_in[int'(pick_idx)*2 +: 2]))
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_NOR:  alu_res = ~(opa | opb);
            default: alu_res = opa & opb;
        endcase
`else
        alu_res = opa & opb;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (acc && pick_any) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
            out_data  <= alu_res;
            out_id    <= pick_idx;
            ptr       <= (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
        end else if (acc) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
        end
    end

endmodule
